// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder.
//   state_t       : FSM state encoding (IDLE, RUN, DONE)
//   cnt_width()   : bit-counter width for a given operand width, never below 1
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// Single-bit combinational full adder used as the per-bit cell of serial_adder.
//   a, b, cin : operand bits and carry-in
//   sum, cout : sum bit and carry-out
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: captures a, b, cin on an accepted start, then
// adds one bit per clock (LSB first) through one full_adder with a registered
// carry. sum/cout/ovf are loaded on the last RUN edge and held until the next
// operation completes; done pulses for one cycle when they become valid.
//   clk, rst  : clock, synchronous active-high reset
//   start     : request, accepted in IDLE and in the DONE cycle
//   a, b, cin : operands, captured on accepted start
//   busy      : high in RUN and DONE
//   done      : one-cycle result-valid pulse
//   sum, cout : (a+b+cin) mod 2^WIDTH and carry out of the MSB
//   ovf       : signed overflow (carry into MSB xor carry out)
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one operand bit processed per edge
// DONE  | result valid, done=1 for this cycle
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t state, state_nx;

  logic [WIDTH-1:0] a_sh, b_sh, sum_sh;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             load, last;
  logic             fa_sum, fa_cout;

  full_adder u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // The DONE cycle also accepts start so back-to-back requests issue every
  // WIDTH+1 edges; start arriving during RUN is dropped.
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    last     = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load     = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (cnt == CNT_LAST) begin
          last     = 1'b1;
          state_nx = DONE;
        end
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
        if (start) begin
          load     = 1'b1;
          state_nx = RUN;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else if (load) begin
      a_sh   <= a;
      b_sh   <= b;
      carry  <= cin;
      cnt    <= '0;
      sum_sh <= '0;
    end else if (state == RUN) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      sum_sh <= {fa_sum, sum_sh[WIDTH-1:1]};
      carry  <= fa_cout;
      cnt    <= cnt + 1'b1;
      if (last) begin
        sum  <= {fa_sum, sum_sh[WIDTH-1:1]};
        cout <= fa_cout;
        // carry still holds the carry into the MSB on this edge
        ovf  <= carry ^ fa_cout;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       start8, cin8, busy8, done8, cout8, ovf8;
  logic [7:0] a8, b8, sum8;
  logic       start2, cin2, busy2, done2, cout2, ovf2;
  logic [1:0] a2, b2, sum2;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  serial_adder #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .cin(cin2),
    .busy(busy2), .done(done2), .sum(sum2), .cout(cout2), .ovf(ovf2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer addition, signed overflow from operand/result signs.
  task automatic model(input int w, input int a, input int b, input int c,
                       output int s, output int co, output int ov);
    int full, msk, sa, sb, ss;
    msk  = (1 << w) - 1;
    full = a + b + c;
    s    = full & msk;
    co   = (full >> w) & 1;
    sa   = (a >> (w - 1)) & 1;
    sb   = (b >> (w - 1)) & 1;
    ss   = (s >> (w - 1)) & 1;
    ov   = (sa == sb && ss != sa) ? 1 : 0;
  endtask

  // Wait for done on the 8-bit DUT; returns cycles counted from the first
  // negedge after the accepting edge.
  task automatic wait_done8(output int cyc);
    cyc = 0;
    while (done8 !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                     input string tag);
    int cyc, es, ec, eo;
    model(8, int'(a), int'(b), int'(c), es, ec, eo);
    @(negedge clk);
    a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    wait_done8(cyc);
    chk({tag, "_latency"}, cyc, 8);
    chk({tag, "_sum"}, sum8, es);
    chk({tag, "_cout"}, cout8, ec);
    chk({tag, "_ovf"}, ovf8, eo);
    @(negedge clk);
    chk({tag, "_busy_after"}, busy8, 0);
    chk({tag, "_done_width"}, done8, 0);
    @(negedge clk);
    chk({tag, "_sum_held"}, sum8, es);
  endtask

  initial begin
    int cyc, es, ec, eo, seen;
    rst = 1'b1;
    start8 = 0; a8 = 0; b8 = 0; cin8 = 0;
    start2 = 0; a2 = 0; b2 = 0; cin2 = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_busy", busy8, 0);
    chk("reset_done", done8, 0);
    chk("reset_sum", sum8, 0);
    chk("reset_cout", cout8, 0);
    chk("reset_ovf", ovf8, 0);

    op8(8'h5A, 8'h3C, 1'b0, "5a_3c");
    chk("5a_3c_const_sum", sum8, 8'h96);
    chk("5a_3c_const_ovf", ovf8, 1);
    op8(8'hFF, 8'h01, 1'b0, "ff_01");
    chk("ff_01_const", {cout8, ovf8, sum8}, {1'b1, 1'b0, 8'h00});
    op8(8'h80, 8'h80, 1'b0, "80_80");
    chk("80_80_const", {cout8, ovf8, sum8}, {1'b1, 1'b1, 8'h00});
    op8(8'h00, 8'h00, 1'b1, "00_00_c");
    chk("00_00_c_const", {cout8, ovf8, sum8}, {1'b0, 1'b0, 8'h01});
    op8(8'hFF, 8'hFF, 1'b1, "ff_ff_c");
    chk("ff_ff_c_const", {cout8, ovf8, sum8}, {1'b1, 1'b0, 8'hFF});

    // start held high through RUN/DONE with different operands
    @(negedge clk);
    a8 = 8'h10; b8 = 8'h20; cin8 = 0; start8 = 1'b1;
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'hFF;
    wait_done8(cyc);
    chk("hold_first_latency", cyc, 8);
    chk("hold_first_sum", sum8, 8'h30);
    @(negedge clk);
    chk("hold_second_busy", busy8, 1);
    chk("hold_second_done_low", done8, 0);
    start8 = 1'b0;
    wait_done8(cyc);
    chk("hold_second_latency", cyc, 8);
    chk("hold_second_sum", sum8, 8'hFE);
    chk("hold_second_cout", cout8, 1);
    chk("hold_second_ovf", ovf8, 0);
    @(negedge clk);
    chk("hold_second_busy_after", busy8, 0);

    // reset in the middle of RUN
    @(negedge clk);
    a8 = 8'h7F; b8 = 8'h01; cin8 = 0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_outputs", {busy8, done8, cout8, ovf8, sum8}, 12'h000);
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8 === 1'b1) seen++;
    end
    chk("midrst_no_done", seen, 0);
    op8(8'h7F, 8'h01, 1'b0, "7f_01");
    chk("7f_01_const", {ovf8, sum8}, {1'b1, 8'h80});

    // randomized operations against the reference model
    for (int i = 0; i < 30; i++) begin
      op8(8'($urandom), 8'($urandom), 1'($urandom), "rand8");
    end

    // WIDTH=2 exhaustive
    for (int v = 0; v < 32; v++) begin
      model(2, v & 3, (v >> 2) & 3, (v >> 4) & 1, es, ec, eo);
      @(negedge clk);
      a2 = 2'(v); b2 = 2'(v >> 2); cin2 = 1'(v >> 4); start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      a2 = 2'($urandom); b2 = 2'($urandom); cin2 = 1'($urandom);
      cyc = 0;
      while (done2 !== 1'b1 && cyc < 10) begin
        @(negedge clk);
        cyc++;
      end
      chk("w2_latency", cyc, 2);
      chk("w2_result", {cout2, ovf2, sum2}, {1'(ec), 1'(eo), 2'(es)});
      @(negedge clk);
      chk("w2_done_width", done2, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
